exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage: it consumes ds_to_es_bus and feeds the memory stage.
- Performs ALU operations and issues the data-SRAM request for lw/sw.
- Owns the HI/LO registers: single-cycle mult/multu, iterative 32-step div/divu, and mfhi/mflo/mthi/mtlo.
- Drives es_fwd_bus so that decode can forward results or stall on a load-use hazard.

---
 rtl/exe_stage_pkg.sv | 79 +++++++
 rtl/exe_stage_div.sv | 85 ++++++++
 rtl/exe_stage.sv | 123 ++++++++++++
 tb/tb_exe_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared bus widths, the decode->execute bus layout, the
// divider state encoding and the combinational ALU used by the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 145;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int ALU_OP_WD       = 12;

  // Field order matches the packed decode bus, MSB first.
  typedef struct packed {
    logic                 mult;
    logic                 multu;
    logic                 div;
    logic                 divu;
    logic                 mfhi;
    logic                 mflo;
    logic                 mthi;
    logic                 mtlo;
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_uimm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [15:0]          imm;
    logic [31:0]          rs_value;
    logic [31:0]          rt_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  // Bit positions inside the one-hot alu_op.
  typedef enum int unsigned {
    OP_ADD  = 0,
    OP_SUB  = 1,
    OP_SLT  = 2,
    OP_SLTU = 3,
    OP_AND  = 4,
    OP_NOR  = 5,
    OP_OR   = 6,
    OP_XOR  = 7,
    OP_SLL  = 8,
    OP_SRL  = 9,
    OP_SRA  = 10,
    OP_LUI  = 11
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  // Shifts move src2 by src1[4:0]; lui places src2[15:0] in the upper half.
  function automatic logic [31:0] alu(input logic [ALU_OP_WD-1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] res;
    res = '0;
    if (op[OP_ADD])  res = res | (a + b);
    if (op[OP_SUB])  res = res | (a - b);
    if (op[OP_SLT])  res = res | {31'b0, ($signed(a) < $signed(b))};
    if (op[OP_SLTU]) res = res | {31'b0, (a < b)};
    if (op[OP_AND])  res = res | (a & b);
    if (op[OP_NOR])  res = res | ~(a | b);
    if (op[OP_OR])   res = res | (a | b);
    if (op[OP_XOR])  res = res | (a ^ b);
    if (op[OP_SLL])  res = res | (b << a[4:0]);
    if (op[OP_SRL])  res = res | (b >> a[4:0]);
    if (op[OP_SRA])  res = res | 32'($signed(b) >>> a[4:0]);
    if (op[OP_LUI])  res = res | {b[15:0], 16'b0};
    return res;
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
//   start      one-cycle launch, samples x/y/signed_op
//   busy       iterations in progress
//   done       result valid, held until ack
//   q, r       sign-corrected quotient and remainder
// Divide by zero yields an all-ones magnitude quotient and the dividend
// magnitude as remainder, before sign correction.
import exe_stage_pkg::*;

module div_iter #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q, rem_q, den_q;
  logic        negq_q, negr_q;

  logic        x_neg, y_neg;
  logic [32:0] rem_shift;
  logic        ge;
  logic [31:0] diff;

  assign x_neg     = signed_op & x[31];
  assign y_neg     = signed_op & y[31];
  // quo_q starts as the dividend and shifts quotient bits in from the right.
  assign rem_shift = {rem_q, quo_q[31]};
  assign ge        = rem_shift >= {1'b0, den_q};
  assign diff      = rem_shift[31:0] - den_q;

  assign busy = (state_q == DIV_BUSY);
  assign done = (state_q == DIV_DONE);
  assign q    = negq_q ? -quo_q : quo_q;
  assign r    = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == 6'(DIV_STEPS - 1)) state_d = DIV_DONE;
      DIV_DONE: if (ack) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (state_q == DIV_IDLE && start) begin
      cnt_q  <= '0;
      quo_q  <= x_neg ? -x : x;
      rem_q  <= '0;
      den_q  <= y_neg ? -y : y;
      negq_q <= x_neg ^ y_neg;
      negr_q <= x_neg;
    end else if (state_q == DIV_BUSY) begin
      cnt_q <= cnt_q + 6'd1;
      rem_q <= ge ? diff : rem_shift[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage MIPS pipeline.
//   clk, reset                 clock, async active-high reset
//   ds_to_es_valid/_bus        instruction from decode; es_allowin back
//   es_to_ms_valid/_bus        result toward memory stage; ms_allowin back
//   es_fwd_bus                 {load, block_valid, dest, result} for decode
//   data_sram_*                data-SRAM request issued in this stage
// Owns HI/LO: mult/multu, iterative div/divu, mfhi/mflo/mthi/mtlo.
import exe_stage_pkg::*;

module exe_stage #(
  parameter int DIV_STEPS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic        es_valid_q;
  ds_to_es_t   bus_q;
  logic [31:0] hi_q, lo_q;

  logic        is_div, es_ready_go, handoff;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [31:0] src1, src2, alu_result, es_result;
  logic signed [63:0] mul_a, mul_b, prod;

  assign is_div      = bus_q.div | bus_q.divu;
  assign es_ready_go = !(is_div && !div_done);
  assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign handoff     = es_to_ms_valid && ms_allowin;
  assign div_start   = es_valid_q && is_div && !div_busy && !div_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) es_valid_q <= 1'b0;
    else if (es_allowin) es_valid_q <= ds_to_es_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_q <= '0;
    else if (ds_to_es_valid && es_allowin) bus_q <= ds_to_es_bus;
  end

  always_comb begin
    src1 = bus_q.rs_value;
    if (bus_q.src1_is_sa)      src1 = {27'b0, bus_q.imm[10:6]};
    else if (bus_q.src1_is_pc) src1 = bus_q.pc;
    src2 = bus_q.rt_value;
    if (bus_q.src2_is_imm)       src2 = {{16{bus_q.imm[15]}}, bus_q.imm};
    else if (bus_q.src2_is_uimm) src2 = {16'b0, bus_q.imm};
    else if (bus_q.src2_is_8)    src2 = 32'd8;
  end

  assign alu_result = alu(bus_q.alu_op, src1, src2);

  // Sign-extend only for signed mult; the low 64 bits of the 64x64 product
  // are the exact 32x32 result in both modes.
  assign mul_a = {{32{bus_q.mult & bus_q.rs_value[31]}}, bus_q.rs_value};
  assign mul_b = {{32{bus_q.mult & bus_q.rt_value[31]}}, bus_q.rt_value};
  assign prod  = mul_a * mul_b;

  always_comb begin
    es_result = alu_result;
    if (bus_q.mfhi)      es_result = hi_q;
    else if (bus_q.mflo) es_result = lo_q;
  end

  // HI/LO change only on the handoff edge, so a stalled producer writes once
  // and a directly following mfhi/mflo sees the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (handoff) begin
      if (bus_q.mult || bus_q.multu) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end else if (is_div) begin
        hi_q <= div_r;
        lo_q <= div_q;
      end else if (bus_q.mthi) begin
        hi_q <= bus_q.rs_value;
      end else if (bus_q.mtlo) begin
        lo_q <= bus_q.rs_value;
      end
    end
  end

  div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .signed_op(bus_q.div),
    .x        (bus_q.rs_value),
    .y        (bus_q.rt_value),
    .ack      (handoff && is_div),
    .busy     (div_busy),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  assign data_sram_en    = es_valid_q && (bus_q.load_op || bus_q.mem_we);
  assign data_sram_wen   = (es_valid_q && bus_q.mem_we) ? 4'hF : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rt_value;

  assign es_to_ms_bus = {bus_q.load_op, bus_q.gr_we, bus_q.dest, es_result, bus_q.pc};
  assign es_fwd_bus   = {es_valid_q && bus_q.load_op, es_valid_q && bus_q.gr_we,
                         bus_q.dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ms_allowin = 1'b1;
  logic         ds_to_es_valid = 1'b0;
  logic [144:0] ds_to_es_bus = '0;
  logic         es_allowin, es_to_ms_valid, data_sram_en;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0]  MD_NONE = 8'h00, MD_MULT = 8'h80, MD_MULTU = 8'h40,
                          MD_DIV = 8'h20, MD_DIVU = 8'h10, MD_MFHI = 8'h08,
                          MD_MFLO = 8'h04, MD_MTHI = 8'h02, MD_MTLO = 8'h01;
  localparam logic [11:0] OP_NONE = 12'h000, OP_ADD = 12'h001, OP_SLT = 12'h004,
                          OP_SLTU = 12'h008, OP_OR = 12'h040, OP_SLL = 12'h100,
                          OP_LUI = 12'h800;
  // sel = {load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_uimm, src2_is_8}
  localparam logic [5:0]  S_NONE = 6'b000000, S_LOAD_IMM = 6'b100100, S_SA = 6'b010000,
                          S_IMM = 6'b000100, S_UIMM = 6'b000010, S_PC8 = 6'b001001;

  exe_stage #(.DIV_STEPS(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ms_allowin     (ms_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_fwd_bus     (es_fwd_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [144:0] mk(input logic [7:0] md, input logic [11:0] op,
                                      input logic [5:0] sel, input logic gw,
                                      input logic mw, input logic [4:0] dst,
                                      input logic [15:0] imm, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] pc);
    return {md, op, sel, gw, mw, dst, imm, rs, rt, pc};
  endfunction

  // Present one instruction for a single edge (stage must be accepting).
  task automatic load(input logic [144:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (es_to_ms_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", es_to_ms_valid); end
    n_cmp++; if (es_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_allowin got %b exp 1", es_allowin); end
    n_cmp++; if (data_sram_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b exp 0", data_sram_en); end
    n_cmp++; if (data_sram_wen !== 4'h0) begin n_bad++; $display("FAIL rst_wen got %h exp 0", data_sram_wen); end
    n_cmp++; if (es_fwd_bus[38:37] !== 2'b00) begin n_bad++; $display("FAIL rst_fwd got %b exp 00", es_fwd_bus[38:37]); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addiu();
    load(mk(MD_NONE, OP_ADD, S_IMM, 1'b1, 1'b0, 5'd3, 16'hFFFF, 32'd5, 32'd0, 32'h100));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'd4) begin n_bad++; $display("FAIL addiu_res got %h exp 4", es_fwd_bus[31:0]); end
    n_cmp++; if (es_fwd_bus[38:32] !== 7'b0100011) begin n_bad++; $display("FAIL addiu_fwd got %b exp 0100011", es_fwd_bus[38:32]); end
    n_cmp++; if (es_to_ms_valid !== 1'b1) begin n_bad++; $display("FAIL addiu_valid got %b exp 1", es_to_ms_valid); end
    n_cmp++; if (es_to_ms_bus !== {1'b0, 1'b1, 5'd3, 32'd4, 32'h100}) begin n_bad++; $display("FAIL addiu_msbus got %h", es_to_ms_bus); end
    n_cmp++; if (data_sram_en !== 1'b0) begin n_bad++; $display("FAIL addiu_en got %b exp 0", data_sram_en); end
    drain();
  endtask

  task automatic test_alu_ops();
    logic [144:0] vb[6];
    logic [31:0]  ve[6];
    vb[0] = mk(MD_NONE, OP_SLL,  S_SA,   1'b1, 1'b0, 5'd1, 16'h0100, 32'd0, 32'd1, 32'd0);          ve[0] = 32'd16;
    vb[1] = mk(MD_NONE, OP_LUI,  S_IMM,  1'b1, 1'b0, 5'd1, 16'h1234, 32'd0, 32'd0, 32'd0);          ve[1] = 32'h12340000;
    vb[2] = mk(MD_NONE, OP_ADD,  S_PC8,  1'b1, 1'b0, 5'd31, 16'h0, 32'h55, 32'd0, 32'hBFC00000);    ve[2] = 32'hBFC00008;
    vb[3] = mk(MD_NONE, OP_SLT,  S_NONE, 1'b1, 1'b0, 5'd1, 16'h0, 32'hFFFFFFFF, 32'd1, 32'd0);      ve[3] = 32'd1;
    vb[4] = mk(MD_NONE, OP_SLTU, S_NONE, 1'b1, 1'b0, 5'd1, 16'h0, 32'hFFFFFFFF, 32'd1, 32'd0);      ve[4] = 32'd0;
    vb[5] = mk(MD_NONE, OP_OR,   S_UIMM, 1'b1, 1'b0, 5'd1, 16'h8001, 32'hF0000000, 32'd0, 32'd0);  ve[5] = 32'hF0008001;
    for (int i = 0; i < 6; i++) begin
      load(vb[i]);
      n_cmp++; if (es_fwd_bus[31:0] !== ve[i]) begin n_bad++; $display("FAIL alu_vec%0d got %h exp %h", i, es_fwd_bus[31:0], ve[i]); end
    end
    drain();
  endtask

  task automatic test_lw_stall();
    ms_allowin = 1'b0;
    load(mk(MD_NONE, OP_ADD, S_LOAD_IMM, 1'b1, 1'b0, 5'd4, 16'h0008, 32'h1000, 32'd0, 32'd0));
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (data_sram_addr !== 32'h1008) begin n_bad++; $display("FAIL lw_addr%0d got %h exp 1008", c, data_sram_addr); end
      n_cmp++; if ({data_sram_en, data_sram_wen} !== 5'b10000) begin n_bad++; $display("FAIL lw_en%0d got %b exp 10000", c, {data_sram_en, data_sram_wen}); end
      n_cmp++; if (es_fwd_bus[38] !== 1'b1) begin n_bad++; $display("FAIL lw_load%0d got %b exp 1", c, es_fwd_bus[38]); end
      n_cmp++; if (es_allowin !== 1'b0) begin n_bad++; $display("FAIL lw_allowin%0d got %b exp 0", c, es_allowin); end
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1; #1;
    n_cmp++; if (es_allowin !== 1'b1) begin n_bad++; $display("FAIL lw_release got %b exp 1", es_allowin); end
    n_cmp++; if (es_to_ms_bus[70] !== 1'b1) begin n_bad++; $display("FAIL lw_resmem got %b exp 1", es_to_ms_bus[70]); end
    drain();
    load(mk(MD_NONE, OP_ADD, S_IMM, 1'b0, 1'b1, 5'd0, 16'hFFFC, 32'h2000, 32'hDEADBEEF, 32'd0));
    n_cmp++; if ({data_sram_en, data_sram_wen} !== 5'b11111) begin n_bad++; $display("FAIL sw_en got %b exp 11111", {data_sram_en, data_sram_wen}); end
    n_cmp++; if (data_sram_addr !== 32'h1FFC) begin n_bad++; $display("FAIL sw_addr got %h exp 1ffc", data_sram_addr); end
    n_cmp++; if (data_sram_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata got %h exp deadbeef", data_sram_wdata); end
    n_cmp++; if (es_fwd_bus[38:37] !== 2'b00) begin n_bad++; $display("FAIL sw_fwd got %b exp 00", es_fwd_bus[38:37]); end
    drain();
  endtask

  task automatic test_mult();
    load(mk(MD_MULT, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, 32'hFFFFFFFE, 32'd3, 32'd0));
    load(mk(MD_MFHI, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd8, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h exp ffffffff", es_fwd_bus[31:0]); end
    load(mk(MD_MFLO, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd9, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo got %h exp fffffffa", es_fwd_bus[31:0]); end
    load(mk(MD_MULTU, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, 32'hFFFFFFFE, 32'd3, 32'd0));
    load(mk(MD_MFHI, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd8, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'd2) begin n_bad++; $display("FAIL multu_hi got %h exp 2", es_fwd_bus[31:0]); end
    load(mk(MD_MFLO, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd9, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL multu_lo got %h exp fffffffa", es_fwd_bus[31:0]); end
    drain();
  endtask

  task automatic test_back_to_back();
    load(mk(MD_MTHI, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, 32'h11111111, 32'd0, 32'd0));
    load(mk(MD_MTLO, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, 32'h22222222, 32'd0, 32'd0));
    load(mk(MD_MFHI, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd8, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'h11111111) begin n_bad++; $display("FAIL mthi_hi got %h exp 11111111", es_fwd_bus[31:0]); end
    load(mk(MD_MFLO, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd9, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'h22222222) begin n_bad++; $display("FAIL mtlo_lo got %h exp 22222222", es_fwd_bus[31:0]); end
    drain();
  endtask

  // Divide with the next instruction (mflo) waiting at the input throughout.
  task automatic run_div(input logic [7:0] md, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cnt;
    load(mk(md, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, rs, rt, 32'd0));
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(MD_MFLO, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd9, 16'h0, 32'd0, 32'd0, 32'd0);
    cnt = 0;
    while (!es_to_ms_valid && cnt < 100) begin
      n_cmp++; if ({es_allowin, es_fwd_bus[37]} !== 2'b00) begin n_bad++; $display("FAIL div_hold%0d got %b exp 00", cnt, {es_allowin, es_fwd_bus[37]}); end
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (cnt !== 33) begin n_bad++; $display("FAIL div_stall_cycles got %0d exp 33", cnt); end
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    n_cmp++; if (es_fwd_bus[31:0] !== exp_lo) begin n_bad++; $display("FAIL div_lo got %h exp %h", es_fwd_bus[31:0], exp_lo); end
    load(mk(MD_MFHI, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd8, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== exp_hi) begin n_bad++; $display("FAIL div_hi got %h exp %h", es_fwd_bus[31:0], exp_hi); end
    drain();
  endtask

  task automatic test_div();
    run_div(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div(MD_DIVU, 32'd10, 32'd0, 32'hFFFFFFFF, 32'd10);
  endtask

  task automatic test_reset_mid_div();
    load(mk(MD_DIV, OP_NONE, S_NONE, 1'b0, 1'b0, 5'd0, 16'h0, 32'hFFFFFFF9, 32'd2, 32'd0));
    repeat (16) @(posedge clk);
    #2; reset = 1'b1; #1;
    n_cmp++; if (es_allowin !== 1'b1) begin n_bad++; $display("FAIL mrst_allowin got %b exp 1", es_allowin); end
    n_cmp++; if (es_to_ms_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b exp 0", es_to_ms_valid); end
    n_cmp++; if (dut.u_div.busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b exp 0", dut.u_div.busy); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    load(mk(MD_MFHI, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd8, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'd0) begin n_bad++; $display("FAIL mrst_hi got %h exp 0", es_fwd_bus[31:0]); end
    load(mk(MD_MFLO, OP_NONE, S_NONE, 1'b1, 1'b0, 5'd9, 16'h0, 32'd0, 32'd0, 32'd0));
    n_cmp++; if (es_fwd_bus[31:0] !== 32'd0) begin n_bad++; $display("FAIL mrst_lo got %h exp 0", es_fwd_bus[31:0]); end
    drain();
    run_div(MD_DIV, 32'd100, 32'd7, 32'd14, 32'd2);
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_alu_ops();
    test_lw_stall();
    test_mult();
    test_back_to_back();
    test_div();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
